// File: rtl/dram_pkg.sv
// Shared types for the DRAM address mapper: mapping modes and decoded field bundle.
// Field widths here are the defaults used by dram_addr_mapper_pipe.
package dram_pkg;

   localparam int unsigned DRAM_RANK_W   = 1;
   localparam int unsigned DRAM_BG_W     = 2;
   localparam int unsigned DRAM_BANK_W   = 2;
   localparam int unsigned DRAM_ROW_W    = 14;
   localparam int unsigned DRAM_COL_W    = 10;
   localparam int unsigned DRAM_OFFSET_W = 2;

   typedef enum logic [1:0] {
      RORABGBACO  = 2'd0,
      RORABACOBG  = 2'd1,
      RARAOBGBACO = 2'd2,
      RSVD        = 2'd3
   } map_mode_t;

   typedef struct packed {
      logic [DRAM_RANK_W-1:0]   rank;
      logic [DRAM_BG_W-1:0]     bg;
      logic [DRAM_BANK_W-1:0]   bank;
      logic [DRAM_ROW_W-1:0]    row;
      logic [DRAM_COL_W-1:0]    col;
      logic [DRAM_OFFSET_W-1:0] offset;
   } addr_fields_t;

endpackage

// File: rtl/dram_addr_decode.sv
// Combinational address splitter: (addr, mode) -> field bundle plus range/reserved-mode error.
module dram_addr_decode
   import dram_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned RANK_W   = DRAM_RANK_W,
   parameter int unsigned BG_W     = DRAM_BG_W,
   parameter int unsigned BANK_W   = DRAM_BANK_W,
   parameter int unsigned ROW_W    = DRAM_ROW_W,
   parameter int unsigned COL_W    = DRAM_COL_W,
   parameter int unsigned OFFSET_W = DRAM_OFFSET_W
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  map_mode_t         mode_i,
   output addr_fields_t      fields_o,
   output logic              err_o
);

   localparam int unsigned SUM = RANK_W + BG_W + BANK_W + ROW_W + COL_W + OFFSET_W;

   // Field base positions per mode, LSB up after the byte offset
   localparam int unsigned M0_COL  = OFFSET_W;
   localparam int unsigned M0_BANK = M0_COL + COL_W;
   localparam int unsigned M0_BG   = M0_BANK + BANK_W;
   localparam int unsigned M0_RANK = M0_BG + BG_W;
   localparam int unsigned M0_ROW  = M0_RANK + RANK_W;

   localparam int unsigned M1_BG   = OFFSET_W;
   localparam int unsigned M1_COL  = M1_BG + BG_W;
   localparam int unsigned M1_BANK = M1_COL + COL_W;
   localparam int unsigned M1_RANK = M1_BANK + BANK_W;
   localparam int unsigned M1_ROW  = M1_RANK + RANK_W;

   localparam int unsigned M2_COL  = OFFSET_W;
   localparam int unsigned M2_BANK = M2_COL + COL_W;
   localparam int unsigned M2_BG   = M2_BANK + BANK_W;
   localparam int unsigned M2_ROW  = M2_BG + BG_W;
   localparam int unsigned M2_RANK = M2_ROW + ROW_W;

   logic range_err;
   logic rsvd;

   generate
      if (SUM < ADDR_W) begin : g_range
         assign range_err = |addr_i[ADDR_W-1:SUM];
      end else begin : g_full
         assign range_err = 1'b0;
      end
   endgenerate

   always_comb begin
      fields_o = '0;
      rsvd     = 1'b0;
      case (mode_i)
         RORABGBACO: begin
            fields_o.offset = addr_i[0 +: OFFSET_W];
            fields_o.col    = addr_i[M0_COL +: COL_W];
            fields_o.bank   = addr_i[M0_BANK +: BANK_W];
            fields_o.bg     = addr_i[M0_BG +: BG_W];
            fields_o.rank   = addr_i[M0_RANK +: RANK_W];
            fields_o.row    = addr_i[M0_ROW +: ROW_W];
         end
         RORABACOBG: begin
            fields_o.offset = addr_i[0 +: OFFSET_W];
            fields_o.bg     = addr_i[M1_BG +: BG_W];
            fields_o.col    = addr_i[M1_COL +: COL_W];
            fields_o.bank   = addr_i[M1_BANK +: BANK_W];
            fields_o.rank   = addr_i[M1_RANK +: RANK_W];
            fields_o.row    = addr_i[M1_ROW +: ROW_W];
         end
         RARAOBGBACO: begin
            fields_o.offset = addr_i[0 +: OFFSET_W];
            fields_o.col    = addr_i[M2_COL +: COL_W];
            fields_o.bank   = addr_i[M2_BANK +: BANK_W];
            fields_o.bg     = addr_i[M2_BG +: BG_W];
            fields_o.row    = addr_i[M2_ROW +: ROW_W];
            fields_o.rank   = addr_i[M2_RANK +: RANK_W];
         end
         default: rsvd = 1'b1;
      endcase
      err_o = range_err | rsvd;
   end

endmodule

// File: rtl/dram_addr_mapper_pipe.sv
// Two-stage DRAM address mapper with drain-safe mode switch and saturating error counter.
// Optional bank/BG XOR hashing with the row is enabled by defining DRAM_ADDR_XOR_HASH_EN.
module dram_addr_mapper_pipe
   import dram_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned ID_W     = 4,
   parameter int unsigned RANK_W   = DRAM_RANK_W,
   parameter int unsigned BG_W     = DRAM_BG_W,
   parameter int unsigned BANK_W   = DRAM_BANK_W,
   parameter int unsigned ROW_W    = DRAM_ROW_W,
   parameter int unsigned COL_W    = DRAM_COL_W,
   parameter int unsigned OFFSET_W = DRAM_OFFSET_W
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [ID_W-1:0]     in_id,
   input  logic                cfg_wr,
   input  logic [1:0]          cfg_mode,
   output logic                cfg_busy,
   output logic [1:0]          cur_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [RANK_W-1:0]   out_rank,
   output logic [BG_W-1:0]     out_bg,
   output logic [BANK_W-1:0]   out_bank,
   output logic [ROW_W-1:0]    out_row,
   output logic [COL_W-1:0]    out_col,
   output logic [OFFSET_W-1:0] out_offset,
   output logic [ID_W-1:0]     out_id,
   output logic                out_err,
   output logic [15:0]         err_cnt
);

   localparam int unsigned SUM = RANK_W + BG_W + BANK_W + ROW_W + COL_W + OFFSET_W;

   generate
      if (SUM > ADDR_W) begin : g_bad_sum
         $error("dram_addr_mapper_pipe: field widths exceed ADDR_W");
      end
      // The field bundle type is sized by the package, so widths must agree with it
      if (RANK_W != DRAM_RANK_W || BG_W != DRAM_BG_W || BANK_W != DRAM_BANK_W ||
          ROW_W != DRAM_ROW_W || COL_W != DRAM_COL_W || OFFSET_W != DRAM_OFFSET_W) begin : g_bad_w
         $error("dram_addr_mapper_pipe: field widths differ from dram_pkg");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t        state_q, state_d;
   map_mode_t     cur_mode_q, cur_mode_d;
   map_mode_t     pend_mode_q, pend_mode_d;

   logic              s1_valid_q;
   logic [ADDR_W-1:0] s1_addr_q;
   logic [ID_W-1:0]   s1_id_q;
   map_mode_t         s1_mode_q;

   logic              out_valid_q;
   addr_fields_t      out_fields_q;
   logic [ID_W-1:0]   out_id_q;
   logic              out_err_q;
   logic [15:0]       err_cnt_q, err_cnt_d;

   logic              s2_load, s1_can_load, accept;
   addr_fields_t      dec_fields, s2_fields;
   logic              dec_err;

   assign s2_load     = !out_valid_q || out_ready;
   assign s1_can_load = !s1_valid_q || s2_load;
   assign in_ready    = (state_q == ST_IDLE) && s1_can_load;
   assign accept      = in_valid && in_ready;

   dram_addr_decode #(
      .ADDR_W   (ADDR_W),
      .RANK_W   (RANK_W),
      .BG_W     (BG_W),
      .BANK_W   (BANK_W),
      .ROW_W    (ROW_W),
      .COL_W    (COL_W),
      .OFFSET_W (OFFSET_W)
   ) u_decode (
      .addr_i   (s1_addr_q),
      .mode_i   (s1_mode_q),
      .fields_o (dec_fields),
      .err_o    (dec_err)
   );

`ifdef DRAM_ADDR_XOR_HASH_EN
   generate
      if (ROW_W < BANK_W + BG_W) begin : g_bad_hash
         $error("dram_addr_mapper_pipe: ROW_W too narrow for XOR hashing");
      end
   endgenerate

   always_comb begin
      s2_fields      = dec_fields;
      s2_fields.bank = dec_fields.bank ^ dec_fields.row[BANK_W-1:0];
      s2_fields.bg   = dec_fields.bg ^ dec_fields.row[BANK_W +: BG_W];
   end
`else
   assign s2_fields = dec_fields;
`endif

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_valid_q && out_ready && out_err_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q   <= 1'b0;
         s1_addr_q    <= '0;
         s1_id_q      <= '0;
         s1_mode_q    <= RORABGBACO;
         out_valid_q  <= 1'b0;
         out_fields_q <= '0;
         out_id_q     <= '0;
         out_err_q    <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         if (s1_can_load) begin
            s1_valid_q <= accept;
            if (accept) begin
               s1_addr_q <= in_addr;
               s1_id_q   <= in_id;
               s1_mode_q <= cur_mode_q;
            end
         end
         if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_fields_q <= s2_fields;
               out_id_q     <= s1_id_q;
               out_err_q    <= dec_err;
            end
         end
         err_cnt_q <= err_cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cur_mode_q  <= RORABGBACO;
         pend_mode_q <= RORABGBACO;
      end else begin
         state_q     <= state_d;
         cur_mode_q  <= cur_mode_d;
         pend_mode_q <= pend_mode_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_mode_d  = cur_mode_q;
      pend_mode_d = pend_mode_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_wr) begin
               state_d     = ST_DRAIN;
               pend_mode_d = map_mode_t'(cfg_mode);
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_q && !out_valid_q) state_d = ST_SWITCH;
         end
         ST_SWITCH: begin
            cur_mode_d = pend_mode_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg_busy   = (state_q != ST_IDLE);
   assign cur_mode   = cur_mode_q;
   assign out_valid  = out_valid_q;
   assign out_rank   = out_fields_q.rank;
   assign out_bg     = out_fields_q.bg;
   assign out_bank   = out_fields_q.bank;
   assign out_row    = out_fields_q.row;
   assign out_col    = out_fields_q.col;
   assign out_offset = out_fields_q.offset;
   assign out_id     = out_id_q;
   assign out_err    = out_err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_dram_addr_mapper_pipe.sv
// Self-checking bench for dram_addr_mapper_pipe: directed steps plus random traffic
// scored against an arithmetic field-order model (honours DRAM_ADDR_XOR_HASH_EN).
module tb_dram_addr_mapper_pipe;

   localparam int ADDR_W = 32;
   localparam int ID_W   = 4;
   localparam int SUM    = 31;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready;
   logic [31:0] in_addr;
   logic [3:0]  in_id;
   logic        cfg_wr, cfg_busy;
   logic [1:0]  cfg_mode, cur_mode;
   logic        out_valid, out_ready;
   logic [0:0]  out_rank;
   logic [1:0]  out_bg, out_bank, out_offset;
   logic [13:0] out_row;
   logic [9:0]  out_col;
   logic [3:0]  out_id;
   logic        out_err;
   logic [15:0] err_cnt;

   always #5 CLK = ~CLK;

   dram_addr_mapper_pipe #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_id(in_id),
      .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_busy(cfg_busy), .cur_mode(cur_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rank(out_rank), .out_bg(out_bg), .out_bank(out_bank), .out_row(out_row),
      .out_col(out_col), .out_offset(out_offset), .out_id(out_id), .out_err(out_err),
      .err_cnt(err_cnt)
   );

   typedef struct { logic [31:0] addr; logic [3:0] id; } req_t;

   req_t        tx_q[$];
   logic [35:0] exp_q[$];
   int unsigned checks = 0, failures = 0;
   int unsigned model_cnt = 0;
   int          exp_mode = 0;
   bit          rand_ready = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] bundle();
      return {out_rank, out_bg, out_bank, out_row, out_col, out_offset, out_id, out_err};
   endfunction

   // Fields are carved off LSB-first in the listed order: 0=col 1=bank 2=bg 3=rank 4=row
   function automatic logic [35:0] model(input logic [31:0] a, input int m, input logic [3:0] id);
      int          w[5];
      int          ord[5];
      logic [63:0] f[5];
      logic [63:0] off;
      int          pos;
      logic        err;
      w = '{10, 2, 2, 1, 14};
      case (m)
         0: ord = '{0, 1, 2, 3, 4};
         1: ord = '{2, 0, 1, 3, 4};
         default: ord = '{0, 1, 2, 4, 3};
      endcase
      pos = 2;
      for (int i = 0; i < 5; i++) begin
         f[ord[i]] = (64'(a) >> pos) % (64'd1 << w[ord[i]]);
         pos += w[ord[i]];
      end
      off = 64'(a) % 4;
      err = ((64'(a) >> SUM) != 0);
      if (m == 3) begin
         for (int i = 0; i < 5; i++) f[i] = 0;
         off = 0;
         err = 1'b1;
      end
`ifdef DRAM_ADDR_XOR_HASH_EN
      f[1] = f[1] ^ (f[4] % 4);
      f[2] = f[2] ^ ((f[4] / 4) % 4);
`endif
      return {f[3][0:0], f[2][1:0], f[1][1:0], f[4][13:0], f[0][9:0], off[1:0], id, err};
   endfunction

   task automatic push_req(input logic [31:0] a);
      req_t r;
      r.addr = a;
      r.id   = 4'($urandom);
      tx_q.push_back(r);
   endtask

   // One clock: drive from tx_q, score both handshakes at the falling edge, return #1 after the rise
   task automatic cycle();
      logic [35:0] e;
      req_t        r;
      if (tx_q.size() > 0) begin
         in_valid = 1'b1;
         in_addr  = tx_q[0].addr;
         in_id    = tx_q[0].id;
      end else begin
         in_valid = 1'b0;
         in_addr  = $urandom;
         in_id    = 4'($urandom);
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("err_cnt", err_cnt, model_cnt);
      if (cfg_busy) check("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
         else begin
            e = exp_q.pop_front();
            check("result", bundle(), e);
            if (e[0] && model_cnt != 16'hFFFF) model_cnt++;
         end
      end
      if (in_valid && in_ready) begin
         r = tx_q.pop_front();
         exp_q.push_back(model(r.addr, exp_mode, r.id));
      end
      @(posedge CLK);
      #1;
      cfg_wr = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((tx_q.size() + exp_q.size()) != 0 && n < 200000) begin
         cycle();
         n++;
      end
      check("drain_timeout", tx_q.size() + exp_q.size(), 0);
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 100) begin
         cycle();
         n++;
      end
      check("wait_out_timeout", out_valid, 1);
   endtask

   task automatic set_mode(input int m);
      int n = 0;
      cfg_mode = 2'(m);
      cfg_wr   = 1'b1;
      cycle();
      check("busy_set", cfg_busy, 1);
      cfg_mode = 2'd3;
      cfg_wr   = 1'b1;
      while (cfg_busy && n < 200) begin
         cycle();
         n++;
      end
      check("busy_clear", cfg_busy, 0);
      exp_mode = m;
      check("cur_mode", cur_mode, m);
   endtask

   logic [35:0] snap;

   initial begin
      RST = 1'b1; in_valid = 1'b0; in_addr = '0; in_id = '0;
      cfg_wr = 1'b0; cfg_mode = '0; out_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_fields", bundle(), 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_cur_mode", cur_mode, 0);
      check("rst_cfg_busy", cfg_busy, 0);
      RST = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);

      // Basic decode and 2-cycle latency
      push_req(32'h0000_1004);
      cycle();
      check("t1_accepted", exp_q.size(), 1);
      check("t1_lat_s1", out_valid, 0);
      cycle();
      check("t1_lat_s2", out_valid, 1);
      check("t1_fields", {out_rank, out_bg, out_bank, out_row, out_col, out_offset, out_err},
            {1'b0, 2'd0, 2'd1, 14'd0, 10'd1, 2'd0, 1'b0});
      drain();

      // Out-of-range address
      push_req(32'h8000_0000);
      wait_out();
      check("t3_err", out_err, 1);
      drain();
      cycle();
      check("t3_err_cnt1", err_cnt, 1);

      // Mode change with two requests in flight: both still decode as mode0
      push_req($urandom & 32'h7FFF_FFFF);
      push_req($urandom & 32'h7FFF_FFFF);
      cycle();
      set_mode(1);
      check("t2_drained", exp_q.size(), 0);
      push_req(32'h0000_000C);
      wait_out();
      check("t2_bg", out_bg, 3);
      check("t2_col", out_col, 0);
      drain();

      // Random traffic in each mode with random backpressure
      rand_ready = 1;
      for (int m = 1; m < 4; m++) begin
         if (m != 1) set_mode(m);
         for (int i = 0; i < 40; i++)
            push_req(($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h7FFF_FFFF));
         drain();
      end
      set_mode(0);
      rand_ready = 0;
      out_ready  = 1'b1;

      // Row-based hashing of bank
      push_req(32'h0002_0000);
      wait_out();
      check("t5_row", out_row, 1);
`ifdef DRAM_ADDR_XOR_HASH_EN
      check("t5_bank", out_bank, 1);
`else
      check("t5_bank", out_bank, 0);
`endif
      drain();

      // Backpressure: 3 requests, sink stalled 5 cycles
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_req($urandom & 32'h7FFF_FFFF);
      cycle();
      cycle();
      snap = bundle();
      check("t4_s2_full", out_valid, 1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t4_in_ready_full", in_ready, 0);
         check("t4_out_valid_held", out_valid, 1);
         check("t4_out_stable", bundle(), snap);
      end
      check("t4_pending", tx_q.size(), 1);
      out_ready = 1'b1;
      drain();

      // Saturate the error counter
      for (int i = 0; i < 65536; i++) push_req(32'h8000_0000 | $urandom);
      drain();
      cycle();
      check("t3_sat", err_cnt, 16'hFFFF);
      push_req(32'hFFFF_FFFF);
      drain();
      cycle();
      check("t3_sat_hold", err_cnt, 16'hFFFF);

      // Reset with both stages full
      set_mode(2);
      out_ready = 1'b0;
      push_req($urandom & 32'h7FFF_FFFF);
      push_req($urandom & 32'h7FFF_FFFF);
      cycle();
      cycle();
      check("t6_full", out_valid, 1);
      RST = 1'b1;
      in_valid = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      tx_q.delete();
      exp_q.delete();
      model_cnt = 0;
      exp_mode  = 0;
      check("t6_out_valid", out_valid, 0);
      check("t6_cur_mode", cur_mode, 0);
      check("t6_err_cnt", err_cnt, 0);
      check("t6_cfg_busy", cfg_busy, 0);
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      check("t6_out_valid_next", out_valid, 0);
      for (int i = 0; i < 8; i++) push_req($urandom & 32'h7FFF_FFFF);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
